// File: rtl/pipe_pkg.sv
// Purpose : shared state encoding for the skid pipeline stage.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // State value doubles as the occupancy count (0, 1 or 2 entries).
  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'd0;
  localparam pipe_state_t ST_ONE   = 2'd1;
  localparam pipe_state_t ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_data_reg.sv
// Purpose : WIDTH-bit data register with load enable and synchronous clear.
// Latency : q updates one clock after ld/clr; clr wins over ld.
// Backpressure: none; the owner decides when to load.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (q <= 0)
//   ld, clr   - load d / zero q on the next rising edge
//   d, q      - data in / registered data out
module pipe_data_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Purpose : pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Latency : 1 cycle from in_fire to out_data; 1 beat/cycle while out_ready=1.
// Backpressure: in_ready is decoded from state only (no combinational ready path); drops when 2 entries held.
//
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   flush                  - synchronous kill of all held entries (highest priority)
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake; out_data is the main (head) register
//   occupancy              - entries held: 0, 1 or 2
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit CLEAR_ON_POP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_t      state;
  pipe_state_t      state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_ld;
  logic             main_clr;
  logic             main_from_skid;
  logic             skid_ld;
  logic             skid_clr;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs depend on the state register only.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL);
  assign occupancy = state;
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      // Any beat handshaked this cycle is dropped; a concurrent out_fire
      // still consumes the current head because out_data is the register.
      state_nxt = ST_EMPTY;
      main_clr  = 1'b1;
      skid_clr  = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ld   = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            // Head is stalled: park the new beat behind it.
            skid_ld   = 1'b1;
            state_nxt = ST_FULL;
          end else if (out_fire) begin
            main_clr  = CLEAR_ON_POP;
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = CLEAR_ON_POP;
            state_nxt      = ST_ONE;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  pipe_data_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld),
    .clr (main_clr),
    .d   (main_d),
    .q   (main_q)
  );

  pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .clr (skid_clr),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Purpose : scoreboard bench for pipe_skid_stage, CLEAR_ON_POP=1 and =0 side by side.
// Latency : inputs driven 1 ns after posedge; outputs compared on negedge.
// Backpressure: out_ready driven by directed sequences, then randomly.
module tb_pipe_skid_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready_c1, out_valid_c1, in_ready_c0, out_valid_c0;
  logic [W-1:0] out_data_c1, out_data_c0;
  logic [1:0]   occ_c1, occ_c0;

  // Reference: a queue of every beat the stage should be holding, oldest first.
  logic [W-1:0] sb[$];
  logic         push_now = 1'b0;   // a beat pushed this cycle (not yet visible on outputs)
  logic [W-1:0] stale_val = '0;    // what main holds when empty with CLEAR_ON_POP=0
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_POP(1'b1)) dut_c1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c1), .in_data(in_data),
    .out_valid(out_valid_c1), .out_ready(out_ready), .out_data(out_data_c1),
    .occupancy(occ_c1)
  );

  pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_POP(1'b0)) dut_c0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c0), .in_data(in_data),
    .out_valid(out_valid_c0), .out_ready(out_ready), .out_data(out_data_c0),
    .occupancy(occ_c0)
  );

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int held, input logic [W-1:0] empty_exp,
                           input logic ov, input logic ir, input logic [1:0] occ,
                           input logic [W-1:0] od);
    cmp({tag, ".out_valid"}, W'(ov), W'(held > 0));
    cmp({tag, ".in_ready"}, W'(ir), W'(held < 2));
    cmp({tag, ".occupancy"}, W'(occ), W'(held));
    if (held > 0) cmp({tag, ".out_data"}, od, sb[0]);
    else          cmp({tag, ".out_data_empty"}, od, empty_exp);
  endtask

  // Monitor: compare outputs every cycle, then retire beats per the handshake.
  always @(negedge clk) begin
    int           held;
    logic [W-1:0] popped;
    if (rst) begin
      sb.delete();
      stale_val = '0;
      check_dut("c1", 0, '0, out_valid_c1, in_ready_c1, occ_c1, out_data_c1);
      check_dut("c0", 0, '0, out_valid_c0, in_ready_c0, occ_c0, out_data_c0);
    end else begin
      held = sb.size() - (push_now ? 1 : 0);
      check_dut("c1", held, '0,        out_valid_c1, in_ready_c1, occ_c1, out_data_c1);
      check_dut("c0", held, stale_val, out_valid_c0, in_ready_c0, occ_c0, out_data_c0);
      if (held > 0 && out_ready) begin
        popped = sb.pop_front();
        if (sb.size() == 0) stale_val = popped;
      end
      if (flush) begin
        sb.delete();
        stale_val = '0;
      end
    end
  end

  // Driver: apply one cycle of stimulus; the accepted beat goes to the scoreboard.
  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #3;
    // The model's own count decides acceptance: at most 2 held, nothing kept on flush.
    push_now = iv && !fl && (sb.size() < 2);
    if (push_now) sb.push_back(id);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    push_now = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    // Reset mid-stream with two entries held, then first beat after release.
    drive(1'b1, 32'hAA, 1'b0, 1'b0);
    drive(1'b1, 32'hBB, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();
    drive(1'b1, 32'h11, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    // Streaming 0x01..0x08.
    for (int i = 1; i <= 8; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    // Stall / skid: 0xA, 0xB held, 0xC waits upstream.
    drive(1'b1, 32'hA, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    drive(1'b1, 32'hC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    // Flush while FULL with a stall.
    drive(1'b1, 32'h5, 1'b0, 1'b0);
    drive(1'b1, 32'h6, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    // Flush with simultaneous out_fire and in_fire.
    drive(1'b1, 32'h7, 1'b0, 1'b0);
    drive(1'b1, 32'h8, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    // Last pop: cleared vs stale data.
    drive(1'b1, 32'h3C, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    // Random traffic with occasional flush.
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
